// File: rtl/lab4_adder_sequencer_pkg.sv
// Shared types and defaults for the time-multiplexed slice adder.
package lab4_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int SLICE_W_DEF = 8;
    localparam int ID_W        = 1;
    localparam int OPCNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice-counter width; a single-slice build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lab4_adder_sequencer_if.sv
// Requester and result channels of the slice adder; master = requesters/consumer, slave = engine.
interface lab4_adder_sequencer_if #(
    parameter int DATA_W = lab4_pkg::DATA_W_DEF
);

    logic                      r0_valid;
    logic [DATA_W-1:0]         r0_xin;
    logic [DATA_W-1:0]         r0_yin;
    logic                      r0_czin;
    logic                      r0_ready;

    logic                      r1_valid;
    logic [DATA_W-1:0]         r1_xin;
    logic [DATA_W-1:0]         r1_yin;
    logic                      r1_czin;
    logic                      r1_ready;

    logic                      res_valid;
    logic                      res_ready;
    logic [lab4_pkg::ID_W-1:0] res_id;
    logic [DATA_W-1:0]         res_fsum;
    logic                      res_fcout;

    modport master (
        output r0_valid, r0_xin, r0_yin, r0_czin,
        input  r0_ready,
        output r1_valid, r1_xin, r1_yin, r1_czin,
        input  r1_ready,
        input  res_valid, res_id, res_fsum, res_fcout,
        output res_ready
    );

    modport slave (
        input  r0_valid, r0_xin, r0_yin, r0_czin,
        output r0_ready,
        input  r1_valid, r1_xin, r1_yin, r1_czin,
        output r1_ready,
        output res_valid, res_id, res_fsum, res_fcout,
        input  res_ready
    );

endinterface

// File: rtl/lab4_adder_sequencer_add_slice.sv
// Purely combinational SLICE_W-bit ripple-carry adder shared by both requesters.
module add_slice #(
    parameter int SLICE_W = lab4_pkg::SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    always_comb begin : ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/lab4_adder_sequencer.sv
// Two-requester add engine: round-robin grant, then one shared slice adder walked LSB first
// with the carry chained through a register; result returned on a valid/ready channel.
module lab4_adder_sequencer
    import lab4_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    lab4_adder_sequencer_if.slave bus,
    output logic                  busy,
    output logic [OPCNT_W-1:0]    op_count
);

    localparam int                NSLICE     = DATA_W / SLICE_W;
    localparam int                CNT_W      = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0]  LAST_SLICE = CNT_W'(NSLICE - 1);

    generate
        if (NSLICE * SLICE_W != DATA_W) begin : g_bad_width
            $error("DATA_W must be an integer multiple of SLICE_W");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OPCNT_W-1:0]  op_count_q, op_count_d;

    logic                req_any;
    logic [ID_W-1:0]     gnt_id;
    logic                accept;
    logic [SLICE_W-1:0]  sl_a, sl_b, sl_s;
    logic                sl_co;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            sum_q      <= '0;
            id_q       <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sum_q      <= sum_d;
            id_q       <= id_d;
            op_count_q <= op_count_d;
        end
    end

    // Tie goes to rr_ptr; ready is suppressed while reset is held so nothing is acknowledged and lost.
    always_comb begin
        req_any = bus.r0_valid | bus.r1_valid;
        gnt_id  = (bus.r0_valid & bus.r1_valid) ? rr_ptr_q : bus.r1_valid;
        accept  = (state_q == IDLE) & req_any & ~rst;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = RUN;
            RUN:     if (cnt_q == LAST_SLICE) state_d = DONE;
            DONE:    if (bus.res_ready)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                sl_a = x_q[i*SLICE_W +: SLICE_W];
                sl_b = y_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add_slice #(.SLICE_W(SLICE_W)) u_add_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = (gnt_id == 1'b1) ? bus.r1_xin  : bus.r0_xin;
                    y_d     = (gnt_id == 1'b1) ? bus.r1_yin  : bus.r0_yin;
                    carry_d = (gnt_id == 1'b1) ? bus.r1_czin : bus.r0_czin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    id_d    = gnt_id;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CNT_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = sl_s;
                end
                carry_d = sl_co;
                cnt_d   = (cnt_q == LAST_SLICE) ? '0 : cnt_q + 1'b1;
            end
            DONE: begin
                if (bus.res_ready) begin
                    rr_ptr_d   = ~id_q;
                    op_count_d = op_count_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.r0_ready  = accept & (gnt_id == 1'b0);
    assign bus.r1_ready  = accept & (gnt_id == 1'b1);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_id    = id_q;
    assign bus.res_fsum  = sum_q;
    assign bus.res_fcout = carry_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;

endmodule

// File: doc/lab4_adder_sequencer.md
Name: lab4_adder_sequencer

Overview:
- Time-multiplexed 16-bit add engine. Two requesters share one SLICE_W-bit ripple-carry adder slice.
- A round-robin arbiter grants one requester at a time.
- A sequencer then walks the operands slice by slice, least significant first, chaining the carry through a register.
- The result is returned on a single valid/ready result channel tagged with the requester id. The block replaces a full-width combinational adder where area matters more than latency.

Parameters:
- DATA_W, 16, operand/sum width; must be an integer multiple of SLICE_W.
- SLICE_W, 8, width of the shared adder slice.
- NSLICE, DATA_W/SLICE_W (derived, not overridable), number of slice passes per operation.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation pending.
- r0_xin  in  DATA_W  requester 0 operand X.
- r0_yin  in  DATA_W  requester 0 operand Y.
- r0_czin  in  1  requester 0 carry-in.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r1_valid, r1_xin, r1_yin, r1_czin, r1_ready: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  1  requester that owns the result.
- res_fsum  out  DATA_W  sum.
- res_fcout  out  1  final carry-out.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  number of completed (handed-off) results.

Behaviour:
- Reset: rst sampled at rising edge. FSM goes to IDLE; rr_ptr=0; slice counter=0; carry reg=0; operand/sum regs=0. Outputs res_valid=0, res_id=0, res_fsum=0, res_fcout=0, busy=0, op_count=0, r0_ready=r1_ready=0.
- Reset mid-operation: the in-flight operation is discarded and no result is produced. The requester does not re-present it automatically.
- FSM states: IDLE, RUN, DONE.
- IDLE, grant rules:
  - Only r0_valid is high: grant 0.
  - Only r1_valid is high: grant 1.
  - Both are high: grant rr_ptr.
- IDLE, accept: rK_ready=1 combinationally for the granted K only. On the edge, latch xin, yin, czin into internal regs, load carry reg=czin, set slice counter=0, record id=K, then go to RUN. With no valid, stay in IDLE and both readys stay 0.
- RUN:
  - Each cycle, apply slice i = x[i*SLICE_W +: SLICE_W] + y[same] + carry reg.
  - Write the slice sum into sum[i*SLICE_W +: SLICE_W] and the slice carry-out into the carry reg.
  - Counter i increments. After slice NSLICE-1, go to DONE.
  - RUN lasts exactly NSLICE cycles.
- DONE:
  - res_valid=1; res_fsum, res_fcout (carry reg) and res_id are registered and stable.
  - On res_valid & res_ready: go to IDLE, set rr_ptr = ~res_id, and op_count += 1 (wraps 0xFFFF to 0).
  - While res_ready=0: hold all outputs unchanged indefinitely.
- Latency: accept edge to res_valid high is NSLICE+1 edges (3 with defaults). Minimum spacing between accepts is NSLICE+2 cycles.
- rK_ready is never high outside IDLE. A request arriving during RUN/DONE waits, with valid held by the requester.
- Arithmetic: {res_fcout,res_fsum} == x + y + czin, exact modulo 2^(DATA_W+1). Carry propagates across slice boundaries only via the carry reg.
- Simultaneous events: res_ready in DONE plus new valid in the same cycle. The handoff completes, and the new request is granted in the following IDLE cycle, using the updated rr_ptr.

Decomposition:
- Shared package lab4_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - DATA_W/SLICE_W defaults;
  - id width constant (1).
- One sub-module, add_slice: purely combinational SLICE_W-bit ripple-carry adder (a, b, ci -> s, co). Instantiated once in the sequencer.

Test Plan:
- Basic add: r0 presents 0x1234+0x5678, czin=0, res_ready=1. Expect r0_ready pulse in cycle 0, res_valid 3 edges later, res_fsum=0x68AC, res_fcout=0, res_id=0, op_count=1.
- Cross-slice carry: r1 presents 0x00FF+0x0000, czin=1. Expect res_fsum=0x0100, fcout=0, res_id=1. Then r1 presents 0xFFFF+0x0001, czin=0; expect res_fsum=0x0000, fcout=1.
- Arbitration:
  - Both valid continuously from reset, with r0 operands 1+1 and r1 operands 2+2. Expect grants alternating 0,1,0,1 and results 2,4,2,4.
  - With r1 valid only, r1 is granted every time.
- Backpressure: hold res_ready=0 for 5 cycles in DONE. Expect res_valid and data stable, busy=1, no ready to a pending r0. Result accepted on the first cycle res_ready=1.
- Reset mid-RUN: assert rst on the 2nd RUN cycle. Expect all outputs zero next cycle, no res_valid, rr_ptr=0 (r0 wins the next tie).
- Random sweep: 300000 random operand/carry/valid/res_ready patterns. Scoreboard compares {fcout,fsum} to x+y+czin per id in order, and the final op_count equals accepted count mod 2^16.
